// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transceiver.
//   - TX / RX state encodings
//   - frame constants (data width, start and stop bit levels)
//   - calc_bit_cycles(): clocks per serial bit, rounded to nearest
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START     = 1'b0;
  localparam logic STOP      = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  function automatic int calc_bit_cycles(input int clk_freq, input int baud_freq);
    return (clk_freq + baud_freq / 2) / baud_freq;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter used to time serial bits.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset (count clears to 0)
//   i_load      load i_load_val this cycle (overrides counting)
//   i_load_val  reload value
//   o_zero      count has reached 0; the counter then holds at 0
module uart_bit_timer #(
  parameter int p_width = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [p_width-1:0] i_load_val,
  output logic               o_zero
);

  logic [p_width-1:0] count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_val;
    end else if (count != '0) begin
      count <= count - p_width'(1);
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver, each timed by
// its own uart_bit_timer so every frame is aligned to its own start edge.
// Ports:
//   i_clk, i_rst          clock and asynchronous active-high reset
//   o_tx                  serial output, idles high
//   o_tx_done             one-cycle pulse after the stop bit completes
//   i_tx_start, i_tx_data transmit request and byte (taken only in TX_IDLE)
//   i_rx                  asynchronous serial input, idles high
//   o_rx_new              one-cycle pulse: byte received with good stop bit
//   o_rx_err              one-cycle pulse: stop bit sampled low
//   o_rx_data             last received byte
//
// state        | meaning
// TX_IDLE      | line high, waiting for i_tx_start
// TX_START     | driving start bit
// TX_DATA      | driving data bits, LSB first
// TX_STOP      | driving stop bit
// RX_IDLE      | waiting for a synchronized low
// RX_START     | timing to mid start bit to reject glitches
// RX_DATA      | sampling data bits at their centres
// RX_STOP      | sampling the stop bit
// RX_WAIT_IDLE | after a framing error, wait for the line to go high
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int p_clk_freq  = 50_000_000,
  parameter int p_baud_freq = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_tx,
  output logic       o_tx_done,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  input  logic       i_rx,
  output logic       o_rx_new,
  output logic       o_rx_err,
  output logic [7:0] o_rx_data
);

  localparam int P = calc_bit_cycles(p_clk_freq, p_baud_freq);
  localparam int W = $clog2(P);
  localparam logic [W-1:0] LD_BIT  = W'(P - 1);
  localparam logic [W-1:0] LD_HALF = W'(P / 2);

  generate
    if (P < 8) begin : g_p_check
      $error("uart_transceiver: fewer than 8 clocks per bit");
    end
  endgenerate

  // ---------------- transmitter ----------------
  tx_state_t  tx_state;
  logic [7:0] tx_shift;
  logic [2:0] tx_idx;
  logic       tx_load;
  logic       tx_zero;

  // Reload on acceptance and at every bit boundary so each bit is exactly P clocks.
  assign tx_load = (tx_state == TX_IDLE) ? i_tx_start : tx_zero;

  uart_bit_timer #(.p_width(W)) u_tx_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tx_load),
    .i_load_val (LD_BIT),
    .o_zero     (tx_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state  <= TX_IDLE;
      tx_shift  <= '0;
      tx_idx    <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (i_tx_start) begin
            tx_shift <= i_tx_data;
            o_tx     <= START;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_zero) begin
            o_tx     <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_zero) begin
            if (tx_idx == 3'(DATA_BITS - 1)) begin
              o_tx     <= STOP;
              tx_state <= TX_STOP;
            end else begin
              o_tx     <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_zero) begin
            o_tx_done <= 1'b1;
            tx_state  <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_s1, rx_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
    end
  end

  rx_state_t  rx_state;
  logic [7:0] rx_shift;
  logic [2:0] rx_idx;
  logic       rx_load;
  logic [W-1:0] rx_load_val;
  logic       rx_zero;

  // Half a bit to reach the start-bit centre, then whole bits from there on.
  always_comb begin
    rx_load     = 1'b0;
    rx_load_val = LD_BIT;
    if (rx_state == RX_IDLE) begin
      rx_load     = ~rx_s2;
      rx_load_val = LD_HALF;
    end else if (rx_state == RX_START || rx_state == RX_DATA) begin
      rx_load     = rx_zero;
    end
  end

  uart_bit_timer #(.p_width(W)) u_rx_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (rx_load),
    .i_load_val (rx_load_val),
    .o_zero     (rx_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state  <= RX_IDLE;
      rx_shift  <= '0;
      rx_idx    <= '0;
      o_rx_new  <= 1'b0;
      o_rx_err  <= 1'b0;
      o_rx_data <= '0;
    end else begin
      o_rx_new <= 1'b0;
      o_rx_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_zero) begin
            if (!rx_s2) begin
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (rx_zero) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_idx == 3'(DATA_BITS - 1)) begin
              rx_state <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (rx_zero) begin
            o_rx_data <= rx_shift;
            if (rx_s2 == STOP) begin
              o_rx_new <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              o_rx_err <= 1'b1;
              rx_state <= RX_WAIT_IDLE;
            end
          end
        end
        RX_WAIT_IDLE: begin
          // A held-low line (break) must not look like a new start bit.
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at 16 clocks per bit.
module tb_uart_transceiver;

  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx = 1'b1;
  logic       o_tx, o_tx_done, o_rx_new, o_rx_err;
  logic [7:0] o_rx_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_new = 0, n_err = 0, n_done = 0, n_both = 0;
  int b_new, b_err, b_done;

  always #5 clk = ~clk;

  uart_transceiver #(
    .p_clk_freq  (1600),
    .p_baud_freq (100)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_tx       (o_tx),
    .o_tx_done  (o_tx_done),
    .i_tx_start (tx_start),
    .i_tx_data  (tx_data),
    .i_rx       (rx),
    .o_rx_new   (o_rx_new),
    .o_rx_err   (o_rx_err),
    .o_rx_data  (o_rx_data)
  );

  always @(negedge clk) begin
    if (o_rx_new) n_new++;
    if (o_rx_err) n_err++;
    if (o_tx_done) n_done++;
    if (o_rx_new && o_rx_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller has raised tx_start with data d at a negedge. Checks every cycle of
  // the frame; a start pulse mid-frame must be ignored. With chain set, a new
  // start (nd) is raised in the o_tx_done cycle.
  task automatic tx_frame(input logic [7:0] d, input logic chain, input logic [7:0] nd);
    logic [9:0] fr;
    logic       exp_tx;
    fr = {1'b1, d, 1'b0};
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    for (int j = 0; j <= 10 * P; j++) begin
      exp_tx = (j < 10 * P) ? fr[j / P] : 1'b1;
      check("tx_line", o_tx, exp_tx);
      check("tx_done", o_tx_done, j == 10 * P);
      if (j == 5 * P) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end
      if (j == 5 * P + 1) tx_start = 1'b0;
      if (j == 10 * P && chain) begin
        tx_start = 1'b1;
        tx_data  = nd;
      end
      if (j < 10 * P) @(negedge clk);
    end
    if (!chain) begin
      @(negedge clk);
      check("tx_done_after", o_tx_done, 1'b0);
      check("tx_idle_after", o_tx, 1'b1);
    end
  endtask

  // Drive one frame on rx from a negedge, then hold low for low_tail clocks.
  task automatic rx_send(input logic [7:0] d, input logic stop, input int low_tail);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = fr[b];
      repeat (P) @(negedge clk);
    end
    if (low_tail > 0) begin
      rx = 1'b0;
      repeat (low_tail) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial begin
    // reset
    repeat (4) @(negedge clk);
    check("rst_tx", o_tx, 1'b1);
    check("rst_rx_data", o_rx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rel_tx", o_tx, 1'b1);
    check("rel_tx_done", o_tx_done, 1'b0);
    check("rel_rx_new", o_rx_new, 1'b0);
    check("rel_rx_err", o_rx_err, 1'b0);
    check("rel_rx_data", o_rx_data, 8'h00);

    // TX 0xA5 followed back-to-back by 0x5A
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    tx_frame(8'hA5, 1'b1, 8'h5A);
    tx_frame(8'h5A, 1'b0, 8'h00);
    check("tx_done_count", n_done, 2);

    // RX valid 0xCC
    b_new = n_new; b_err = n_err;
    rx_send(8'hCC, 1'b1, 0);
    repeat (2 * P) @(negedge clk);
    check("rx_cc_data", o_rx_data, 8'hCC);
    check("rx_cc_new", n_new - b_new, 1);
    check("rx_cc_err", n_err - b_err, 0);

    // RX valid 0x3A
    b_new = n_new; b_err = n_err;
    rx_send(8'h3A, 1'b1, 0);
    repeat (2 * P) @(negedge clk);
    check("rx_3a_data", o_rx_data, 8'h3A);
    check("rx_3a_new", n_new - b_new, 1);
    check("rx_3a_err", n_err - b_err, 0);

    // framing error on 0xCC, line held low two more bits before idling
    b_new = n_new; b_err = n_err;
    rx_send(8'hCC, 1'b0, 2 * P);
    repeat (2 * P) @(negedge clk);
    check("rx_ferr_data", o_rx_data, 8'hCC);
    check("rx_ferr_new", n_new - b_new, 0);
    check("rx_ferr_err", n_err - b_err, 1);

    // next valid frame 0x5E received while TX sends 0xC3
    b_new = n_new; b_err = n_err;
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    fork
      tx_frame(8'hC3, 1'b0, 8'h00);
      rx_send(8'h5E, 1'b1, 0);
    join
    repeat (2 * P) @(negedge clk);
    check("rx_5e_data", o_rx_data, 8'h5E);
    check("rx_5e_new", n_new - b_new, 1);
    check("rx_5e_err", n_err - b_err, 0);

    // false start: 3-clock low glitch
    b_new = n_new; b_err = n_err;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * P) @(negedge clk);
    check("fs_data", o_rx_data, 8'h5E);
    check("fs_new", n_new - b_new, 0);
    check("fs_err", n_err - b_err, 0);

    // reset during TX bit 3 of 0x3B (that bit is 0)
    tx_start = 1'b1;
    tx_data  = 8'h3B;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (3 * P + P / 2) @(negedge clk);
    check("mid_tx_bit3", o_tx, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", o_tx, 1'b1);
    check("mid_rst_done", o_tx_done, 1'b0);
    check("mid_rst_rx_data", o_rx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_done = n_done;
    repeat (12 * P) @(negedge clk);
    check("mid_rst_no_done", n_done - b_done, 0);
    check("mid_rst_idle", o_tx, 1'b1);
    tx_start = 1'b1;
    tx_data  = 8'h3B;
    tx_frame(8'h3B, 1'b0, 8'h00);

    check("rx_new_err_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Full-duplex 8N1 UART transceiver that bridges a single-clock system bus to a serial line. It has an independent transmitter and receiver, each timed by a bit counter derived from the clock and baud frequency parameters. It is the leaf serial-communication block under the comm hierarchy, used by host-facing command and debug paths.

## Interface
- p_clk_freq, 50_000_000: system clock frequency in Hz.
- p_baud_freq, 115_200: baud rate in Hz.
- Derived constant P = (p_clk_freq + p_baud_freq/2) / p_baud_freq, the clock cycles per bit (434 at the defaults). P ≥ 8 is required; elaboration-time assertion otherwise.
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- o_tx  out  1  serial transmit line, idles high.
- o_tx_done  out  1  one-cycle pulse when a frame's stop bit completes.
- i_tx_start  in  1  transmit request, sampled on the clock edge.
- i_tx_data  in  8  byte to transmit, captured together with an accepted i_tx_start.
- i_rx  in  1  asynchronous serial receive line, idles high.
- o_rx_new  out  1  one-cycle pulse when a byte with a valid stop bit has been received.
- o_rx_err  out  1  one-cycle pulse on a framing error (stop bit sampled 0).
- o_rx_data  out  8  last received byte, held until the next frame completes.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Reset values: o_tx=1, o_tx_done=0, o_rx_new=0, o_rx_err=0, o_rx_data=0. Both state machines go to IDLE and counters clear.
- TX states: IDLE → START → DATA (bit index 0..7) → STOP → IDLE.
  - In IDLE, i_tx_start=1 latches i_tx_data into a shift register and enters START.
  - i_tx_start is ignored while TX is not in IDLE.
- RX path: i_rx passes through a 2-flop synchronizer before any use.
- RX states: IDLE → START → DATA → STOP → IDLE, plus WAIT_IDLE.
  - IDLE: a synchronized 0 enters START and loads the counter with P/2.
  - START: at the half-bit point, if the line is still 0, go to DATA. Otherwise it is a false start; return to IDLE with no output.
  - DATA: sample every P cycles from the start mid-point, shifting LSB first.
  - STOP: sample P cycles after the last data bit.
    - Stop sample 1: load o_rx_data, pulse o_rx_new, go to IDLE.
    - Stop sample 0: load o_rx_data anyway, pulse o_rx_err, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line samples 1, then go to IDLE. This stops a held-low line or break from retriggering.
- o_rx_new and o_rx_err are never asserted in the same cycle.
- TX and RX operate fully independently. Simultaneous activity has no interaction.

## Timing
- TX: i_tx_start accepted at edge k puts o_tx=0 after edge k.
- Each TX bit lasts exactly P cycles, so a frame is 10·P cycles.
- o_tx_done is high for the single cycle after the stop bit's P cycles elapse. TX is back in IDLE that cycle.
  - A start asserted in that cycle is accepted, giving back-to-back frames with no idle gap beyond that cycle.
- RX: input latency is 2 cycles through the synchronizer.
- Data bit n is sampled at roughly (1.5+n)·P cycles after the synchronized falling edge.
- o_rx_new / o_rx_err pulse one cycle after the stop sample, at roughly 9.5·P cycles after the start edge. RX then re-arms mid-stop-bit for resynchronization.
- Bit counters are $clog2(P) bits wide, count down to 0 and reload. There is no free-running baud tick, so each engine aligns to its own frame.
- Reset asserted mid-frame aborts immediately and asynchronously:
  - o_tx returns to 1.
  - Pulses drop.
  - o_rx_data clears to 0.

## Structure
- Package uart_pkg holds:
  - TX and RX state enums.
  - A function computing P from the two frequencies.
  - Frame constants: DATA_BITS=8, START=0, STOP=1.
- One sub-module, uart_bit_timer: a loadable down-counter with a zero flag. It is instantiated once for TX and once for RX.
- The TX and RX state machines live in the top module.

## Test plan
- Reset: hold i_rst=1, then release → o_tx=1, o_tx_done=0, o_rx_new=0, o_rx_err=0, o_rx_data=0.
- TX 0xA5: pulse i_tx_start → o_tx shows 0,1,0,1,0,0,1,0,1,1, each bit P cycles long, then a single-cycle o_tx_done.
- RX 0xCC: drive a valid frame at P cycles per bit → o_rx_data=0xCC and one o_rx_new pulse, with no o_rx_err.
- RX framing error: send 0xCC with the stop bit 0, then hold the line high → o_rx_err pulses, o_rx_data=0xCC, no o_rx_new, and the next valid frame is received.
- False start: a 0 glitch shorter than P/2 → no pulse and o_rx_data unchanged.
- Reset mid-TX: assert i_rst during bit 3 → o_tx=1 immediately, no o_tx_done, and the next i_tx_start sends a full frame.
